// File: rtl/housekeeping_spi_pkg.sv
// housekeeping_spi_pkg: FSM state encodings and command-byte bit positions
package housekeeping_spi_pkg;
    typedef enum logic [2:0] {
        COMMAND = 3'b000,
        ADDRESS = 3'b001,
        DATA    = 3'b010,
        PASS    = 3'b100
    } state_t;
    localparam int CMD_WR  = 7;
    localparam int CMD_RD  = 6;
    localparam int CMD_NNN = 3;
    localparam int CMD_CH0 = 2;
endpackage

// File: rtl/housekeeping_spi_shreg.sv
// housekeeping_spi_shreg: negedge readback shift register driving SDO and its enable
module housekeeping_spi_shreg
    import housekeeping_spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              SCK,
    input  logic              csb_reset,
    input  state_t            state,
    input  logic              readmode,
    input  logic [CNT_W-1:0]  bitcnt,
    input  logic [DATA_W-1:0] idata,
    output logic              SDO,
    output logic              sdoenb
);
    logic [DATA_W-1:0] ldata;
    logic              reading;
    assign reading = state == DATA && readmode;
    assign SDO = ldata[DATA_W-1] & (state != PASS);
    always_ff @(negedge SCK or posedge csb_reset) begin
        if (csb_reset) begin
            ldata  <= '0;
            sdoenb <= 1'b1;
        end else begin
            ldata  <= !reading ? '0 : (bitcnt == '0) ? idata : {ldata[DATA_W-2:0], 1'b0};
            sdoenb <= !(reading || state == PASS);
        end
    end
endmodule

// File: rtl/housekeeping_spi_wide.sv
// housekeeping_spi_wide: SCK-clocked housekeeping SPI slave with multi-byte address/data
// words and one-hot selectable flash pass-through channels.
module housekeeping_spi_wide
    import housekeeping_spi_pkg::*;
#(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 1,
    parameter int PASS_CH    = 2,
    localparam int ADDR_W    = 8 * ADDR_BYTES,
    localparam int DATA_W    = 8 * DATA_BYTES
) (
    input  logic               SCK,
    input  logic               reset,
    input  logic               SDI,
    input  logic               CSB,
    output logic               SDO,
    output logic               sdoenb,
    input  logic [DATA_W-1:0]  idata,
    output logic [DATA_W-1:0]  odata,
    output logic [ADDR_W-1:0]  oaddr,
    output logic               rdstb,
    output logic               wrstb,
    output logic [PASS_CH-1:0] pass_thru,
    output logic [PASS_CH-1:0] pass_thru_reset
);
    localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(MAX_W);

    state_t             state, state_n;
    logic [CNT_W-1:0]   bitcnt, bitcnt_n;
    logic [7:0]         cmd, cmd_n;
    logic [2:0]         wcnt, wcnt_n;
    logic [ADDR_W-1:0]  addr, addr_n;
    logic [DATA_W-1:0]  predata;
    logic [PASS_CH-1:0] ptr_n, pass_n;
    logic               rdstb_n, csb_reset;

    assign csb_reset = reset | CSB;
    assign cmd_n = {cmd[6:0], SDI};
    assign odata = {predata[DATA_W-2:0], SDI};
    assign oaddr = (state == ADDRESS) ? {addr[ADDR_W-2:0], SDI} : addr;

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt + CNT_W'(1);
        wcnt_n   = wcnt;
        addr_n   = addr;
        rdstb_n  = 1'b0;
        ptr_n    = pass_thru_reset;
        pass_n   = pass_thru;
        // channel reset requests latch the moment their command bit is sampled
        for (int i = 0; i < PASS_CH; i++)
            if (state == COMMAND && bitcnt == CNT_W'(7 - CMD_CH0 + i) && SDI) ptr_n[i] = 1'b1;
        case (state)
            COMMAND: if (bitcnt == CNT_W'(7)) begin
                state_n  = (ptr_n != '0) ? PASS : ADDRESS;
                bitcnt_n = '0;
                wcnt_n   = cmd_n[CMD_NNN +: 3];
            end
            ADDRESS: begin
                addr_n = oaddr;
                if (bitcnt == CNT_W'(ADDR_W - 1)) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                    rdstb_n  = cmd[CMD_RD];
                end
            end
            DATA: if (bitcnt == CNT_W'(DATA_W - 1)) begin
                bitcnt_n = '0;
                addr_n   = addr + ADDR_W'(1);
                rdstb_n  = cmd[CMD_RD];
                if (wcnt != 3'd0) begin
                    wcnt_n  = wcnt - 3'd1;
                    state_n = (wcnt == 3'd1) ? COMMAND : DATA;
                end
            end
            PASS: begin
                bitcnt_n = bitcnt;
                pass_n   = pass_thru_reset & (~pass_thru_reset + PASS_CH'(1));
            end
            default: state_n = COMMAND;
        endcase
    end

    always_ff @(posedge SCK or posedge csb_reset) begin
        if (csb_reset) begin
            state           <= COMMAND;
            bitcnt          <= '0;
            cmd             <= '0;
            wcnt            <= '0;
            addr            <= '0;
            predata         <= '0;
            rdstb           <= 1'b0;
            pass_thru_reset <= '0;
            pass_thru       <= '0;
        end else begin
            state           <= state_n;
            bitcnt          <= bitcnt_n;
            cmd             <= (state == COMMAND) ? cmd_n : cmd;
            wcnt            <= wcnt_n;
            addr            <= addr_n;
            predata         <= (state == DATA) ? odata : predata;
            rdstb           <= rdstb_n;
            pass_thru_reset <= ptr_n;
            pass_thru       <= pass_n;
        end
    end

    always_ff @(negedge SCK or posedge csb_reset) begin
        if (csb_reset) wrstb <= 1'b0;
        else wrstb <= state == DATA && bitcnt == CNT_W'(DATA_W - 1) && cmd[CMD_WR];
    end

    housekeeping_spi_shreg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shreg (
        .SCK       (SCK),
        .csb_reset (csb_reset),
        .state     (state),
        .readmode  (cmd[CMD_RD]),
        .bitcnt    (bitcnt),
        .idata     (idata),
        .SDO       (SDO),
        .sdoenb    (sdoenb)
    );
endmodule

// File: tb/tb_housekeeping_spi_wide.sv
// tb_housekeeping_spi_wide: frame-level SPI stimulus with a bit-position reference model;
// expected strobes, readback bits and pass-through changes are queued and popped by a monitor.
module tb_housekeeping_spi_wide;
    localparam int AB = 2;
    localparam int DB = 2;
    localparam int PC = 2;
    localparam int AW = 8 * AB;
    localparam int DW = 8 * DB;

    typedef struct {
        int          rise;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic          SCK, reset, SDI, CSB, SDO, sdoenb, rdstb, wrstb;
    logic [DW-1:0] idata, odata;
    logic [AW-1:0] oaddr;
    logic [PC-1:0] pass_thru, pass_thru_reset;
    logic [DW-1:0] rmem [0:2**AW-1];
    bit            fq[$];
    ev_t           wr_q[$], rd_q[$], sdo_q[$], ptr_q[$], pt_q[$];
    int            checks = 0;
    int            errors = 0;

    housekeeping_spi_wide #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .PASS_CH(PC)) dut (
        .SCK             (SCK),
        .reset           (reset),
        .SDI             (SDI),
        .CSB             (CSB),
        .SDO             (SDO),
        .sdoenb          (sdoenb),
        .idata           (idata),
        .odata           (odata),
        .oaddr           (oaddr),
        .rdstb           (rdstb),
        .wrstb           (wrstb),
        .pass_thru       (pass_thru),
        .pass_thru_reset (pass_thru_reset)
    );

    assign idata = rmem[oaddr];

    initial SCK = 1'b0;
    always #5 SCK = ~SCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] field(input int p, input int w);
        logic [31:0] v = '0;
        for (int k = 0; k < w; k++) v = {v[30:0], 1'(fq[p + k])};
        return v;
    endfunction

    task automatic push_bits(input logic [31:0] v, input int w);
        for (int k = w - 1; k >= 0; k--) fq.push_back(v[k]);
    endtask

    // Sample point r sits just before SCK rise r+1, so bit j of the frame is seen by rise j+1
    // and anything registered on that rise is visible at sample point j+1.
    task automatic model();
        int n, pos, cs, win, nw;
        logic [7:0]    c;
        logic [AW-1:0] a;
        logic [PC-1:0] ptr;
        n = fq.size();
        pos = 0;
        ptr = '0;
        while (pos < n) begin
            cs = pos;
            win = -1;
            for (int i = 0; i < PC; i++)
                if (cs + 5 + i < n && fq[cs + 5 + i]) begin
                    ptr[i] = 1'b1;
                    if (win < 0) win = i;
                    if (cs + 6 + i < n) ptr_q.push_back('{cs + 6 + i, 32'(ptr), 0});
                end
            if (cs + 8 > n) return;
            c = 8'(field(cs, 8));
            pos += 8;
            if (win >= 0) begin
                if (cs + 9 < n) pt_q.push_back('{cs + 9, 32'(1) << win, 0});
                for (int r = cs + 8; r < n; r++) sdo_q.push_back('{r, 0, 0});
                return;
            end
            if (pos + AW > n) return;
            a = AW'(field(pos, AW));
            pos += AW;
            if (c[6] && pos < n) rd_q.push_back('{pos, 32'(a), 0});
            nw = 0;
            forever begin
                if (c[6])
                    for (int k = 0; k < DW; k++)
                        if (pos + k < n) sdo_q.push_back('{pos + k, 0, 32'(rmem[a][DW - 1 - k])});
                if (pos + DW > n) return;
                if (c[7]) wr_q.push_back('{pos + DW - 1, 32'(a), field(pos, DW)});
                pos += DW;
                a = a + AW'(1);
                if (c[6] && pos < n) rd_q.push_back('{pos, 32'(a), 0});
                nw++;
                if (c[5:3] != 3'd0 && nw == int'(c[5:3])) break;
            end
        end
    endtask

    task automatic run_frame(input bit use_reset);
        model();
        foreach (fq[j]) begin
            @(negedge SCK);
            CSB = 1'b0;
            SDI = fq[j];
        end
        @(negedge SCK);
        SDI = 1'b0;
        if (use_reset) reset = 1'b1;
        else CSB = 1'b1;
        repeat (2) @(negedge SCK);
        CSB = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge SCK);
        fq.delete();
    endtask

    initial begin
        int r = 0;
        logic [PC-1:0] pptr = '0;
        logic [PC-1:0] ppt = '0;
        ev_t e;
        forever begin
            @(negedge SCK);
            #4;
            if (reset || CSB) begin
                r = 0;
                pptr = '0;
                ppt = '0;
                check("idle_outputs", {SDO, sdoenb, wrstb, rdstb, pass_thru, pass_thru_reset, oaddr},
                      {1'b0, 1'b1, 1'b0, 1'b0, {PC{1'b0}}, {PC{1'b0}}, {AW{1'b0}}});
            end else begin
                if (wrstb) begin
                    check("wrstb_expected", 64'(wr_q.size() != 0), 1);
                    if (wr_q.size() != 0) begin
                        e = wr_q.pop_front();
                        check("wr_bit", r, e.rise);
                        check("wr_addr", oaddr, e.a);
                        check("wr_data", odata, e.d);
                    end
                end
                if (rdstb) begin
                    check("rdstb_expected", 64'(rd_q.size() != 0), 1);
                    if (rd_q.size() != 0) begin
                        e = rd_q.pop_front();
                        check("rd_bit", r, e.rise);
                        check("rd_addr", oaddr, e.a);
                    end
                end
                if (!sdoenb) begin
                    check("sdo_expected", 64'(sdo_q.size() != 0), 1);
                    if (sdo_q.size() != 0) begin
                        e = sdo_q.pop_front();
                        check("sdo_bit", r, e.rise);
                        check("sdo_val", SDO, e.d);
                    end
                end
                if (pass_thru_reset != pptr) begin
                    check("ptr_expected", 64'(ptr_q.size() != 0), 1);
                    if (ptr_q.size() != 0) begin
                        e = ptr_q.pop_front();
                        check("ptr_bit", r, e.rise);
                        check("ptr_val", pass_thru_reset, e.a);
                    end
                    pptr = pass_thru_reset;
                end
                if (pass_thru != ppt) begin
                    check("pass_expected", 64'(pt_q.size() != 0), 1);
                    if (pt_q.size() != 0) begin
                        e = pt_q.pop_front();
                        check("pass_bit", r, e.rise);
                        check("pass_val", pass_thru, e.a);
                    end
                    ppt = pass_thru;
                end
                r++;
            end
        end
    end

    initial begin
        logic [7:0] c;
        int nb;
        reset = 1'b1;
        CSB = 1'b1;
        SDI = 1'b0;
        for (int i = 0; i < 2**AW; i++) rmem[i] = DW'($urandom);
        rmem[{AW{1'b1}}] = 16'hA5C3;
        rmem[0] = 16'h3C5A;
        repeat (3) @(negedge SCK);
        reset = 1'b0;
        repeat (2) @(negedge SCK);
        // fixed two-word write, then a no-op command in the same frame
        push_bits(8'h90, 8); push_bits(16'h1234, AW); push_bits(16'hBEEF, DW); push_bits(16'h0102, DW);
        push_bits(8'h00, 8); push_bits(16'h4444, AW); push_bits(16'h5555, DW);
        run_frame(0);
        // fixed write followed by a second write command in the same frame
        push_bits(8'h90, 8); push_bits(16'h1234, AW); push_bits(16'hBEEF, DW); push_bits(16'h0102, DW);
        push_bits(8'h88, 8); push_bits(16'h0050, AW); push_bits(16'h7777, DW);
        run_frame(0);
        // streaming read across the address wrap
        push_bits(8'h40, 8); push_bits(16'hFFFF, AW); push_bits(0, DW); push_bits(0, DW); push_bits(0, 3);
        run_frame(0);
        // pass-through ch1, closed by CSB then by reset
        push_bits(8'hC2, 8); push_bits(16'hABCD, 16);
        run_frame(0);
        push_bits(8'hC2, 8); push_bits(16'h00FF, 12);
        run_frame(1);
        // out-of-range channel bit falls through to a read/write transfer
        push_bits(8'hC1, 8); push_bits(16'h00A0, AW); push_bits(16'h1111, DW); push_bits(16'h2222, DW);
        run_frame(0);
        // aborted write, then a clean write
        push_bits(8'h80, 8); push_bits(16'h0010, AW); push_bits(5'h15, 5);
        run_frame(0);
        push_bits(8'h88, 8); push_bits(16'h0010, AW); push_bits(16'h1357, DW);
        run_frame(0);
        // reset mid-read, then a clean write
        push_bits(8'h48, 8); push_bits(16'h0003, AW); push_bits(7'h55, 7);
        run_frame(1);
        push_bits(8'h88, 8); push_bits(16'h0020, AW); push_bits(16'h2468, DW);
        run_frame(0);
        for (int f = 0; f < 25; f++) begin
            c = 8'($urandom);
            if ($urandom_range(0, 2) != 0) c[2:1] = 2'b00;
            push_bits(c, 8);
            nb = $urandom_range(0, AW + 3 * DW + 8);
            for (int k = 0; k < nb; k++) fq.push_back(1'($urandom));
            run_frame($urandom_range(0, 4) == 0);
        end
        repeat (4) @(negedge SCK);
        check("wr_queue_drained", wr_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        check("sdo_queue_drained", sdo_q.size(), 0);
        check("ptr_queue_drained", ptr_q.size(), 0);
        check("pass_queue_drained", pt_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
